// File: rtl/video_sync_normalizer.sv
// Sync/blank normalizer ahead of video_mixer: polarity detect, line-aligned
// vblank, RGB blanking and line/frame timing measurement with lock flag.
module video_sync_normalizer #(
  parameter int DW     = 8,
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11
) (
  input  logic              CLK_VIDEO,
  input  logic              RESET_N,
  input  logic              ce_pix,
  input  logic [DW-1:0]     R_in,
  input  logic [DW-1:0]     G_in,
  input  logic [DW-1:0]     B_in,
  input  logic              HSync_in,
  input  logic              VSync_in,
  input  logic              HBlank_in,
  input  logic              VBlank_in,
  output logic [DW-1:0]     R,
  output logic [DW-1:0]     G,
  output logic [DW-1:0]     B,
  output logic              HSync,
  output logic              VSync,
  output logic              HBlank,
  output logic              VBlank,
  output logic              hs_pol,
  output logic              vs_pol,
  output logic [HCNT_W-1:0] h_total,
  output logic [VCNT_W-1:0] v_total,
  output logic              locked
);

  localparam logic [HCNT_W-1:0] H_MAX = '1;
  localparam logic [HCNT_W-1:0] H_ONE = HCNT_W'(1);
  localparam logic [VCNT_W-1:0] V_MAX = '1;
  localparam logic [VCNT_W-1:0] V_ONE = VCNT_W'(1);

  function automatic logic [HCNT_W-1:0] h_inc(
    input logic [HCNT_W-1:0] x
  );
    return (x == H_MAX) ? x : x + H_ONE;
  endfunction

  function automatic logic [VCNT_W-1:0] v_inc(
    input logic [VCNT_W-1:0] x
  );
    return (x == V_MAX) ? x : x + V_ONE;
  endfunction

  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic              hb_prev_q, hb_prev_d;
  logic              h_seen_q, h_seen_d;
  logic              v_seen_q, v_seen_d;
  logic              h_meas_q, h_meas_d;
  logic              v_meas_q, v_meas_d;
  logic              h_ok_q, h_ok_d;
  logic              v_ok_q, v_ok_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [HCNT_W-1:0] hhi_q, hhi_d;
  logic [HCNT_W-1:0] hlo_q, hlo_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [VCNT_W-1:0] vhi_q, vhi_d;
  logic [VCNT_W-1:0] vlo_q, vlo_d;

  logic [DW-1:0]     r_q, r_d;
  logic [DW-1:0]     g_q, g_d;
  logic [DW-1:0]     b_q, b_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              hblank_q, hblank_d;
  logic              vblank_q, vblank_d;
  logic              hs_pol_q, hs_pol_d;
  logic              vs_pol_q, vs_pol_d;
  logic [HCNT_W-1:0] h_total_q, h_total_d;
  logic [VCNT_W-1:0] v_total_q, v_total_d;
  logic              locked_q, locked_d;

  logic              h_rise;
  logic              v_rise;
  logic              hb_rise;
  logic [HCNT_W-1:0] h_len;
  logic [VCNT_W-1:0] vcnt_n;
  logic [VCNT_W-1:0] vhi_n;
  logic [VCNT_W-1:0] vlo_n;
  logic              blank;

  always_comb begin
    h_rise    = ce_pix & HSync_in & ~hs_prev_q;
    v_rise    = ce_pix & VSync_in & ~vs_prev_q;
    hb_rise   = ce_pix & HBlank_in & ~hb_prev_q;
    hs_prev_d = ce_pix ? HSync_in : hs_prev_q;
    vs_prev_d = ce_pix ? VSync_in : vs_prev_q;
    hb_prev_d = ce_pix ? HBlank_in : hb_prev_q;
  end

  // The boundary sample itself opens the new line's duty counts.
  always_comb begin
    hcnt_d    = hcnt_q;
    hhi_d     = hhi_q;
    hlo_d     = hlo_q;
    h_seen_d  = h_seen_q;
    h_meas_d  = h_meas_q;
    h_ok_d    = h_ok_q;
    hs_pol_d  = hs_pol_q;
    h_total_d = h_total_q;
    h_len     = h_inc(hcnt_q);
    if (h_rise) begin
      hcnt_d   = '0;
      hhi_d    = H_ONE;
      hlo_d    = '0;
      h_seen_d = 1'b1;
      if (h_seen_q) begin
        hs_pol_d  = hhi_q > hlo_q;
        h_total_d = h_len;
        h_meas_d  = 1'b1;
        h_ok_d    = h_meas_q
                  & (h_len == h_total_q)
                  & (h_len != H_MAX);
      end
    end else if (ce_pix) begin
      hcnt_d = h_inc(hcnt_q);
      if (HSync_in) begin
        hhi_d = h_inc(hhi_q);
      end else begin
        hlo_d = h_inc(hlo_q);
      end
    end
  end

  // A line ending on the frame boundary still belongs to the old frame.
  always_comb begin
    vcnt_n = h_rise ? v_inc(vcnt_q) : vcnt_q;
    vhi_n  = (h_rise & VSync_in) ? v_inc(vhi_q) : vhi_q;
    vlo_n  = (h_rise & ~VSync_in) ? v_inc(vlo_q) : vlo_q;
  end

  always_comb begin
    vcnt_d    = vcnt_n;
    vhi_d     = vhi_n;
    vlo_d     = vlo_n;
    v_seen_d  = v_seen_q;
    v_meas_d  = v_meas_q;
    v_ok_d    = v_ok_q;
    vs_pol_d  = vs_pol_q;
    v_total_d = v_total_q;
    if (v_rise) begin
      vcnt_d   = '0;
      vhi_d    = '0;
      vlo_d    = '0;
      v_seen_d = 1'b1;
      if (v_seen_q) begin
        vs_pol_d  = vhi_n > vlo_n;
        v_total_d = vcnt_n;
        v_meas_d  = 1'b1;
        v_ok_d    = v_meas_q
                  & (vcnt_n == v_total_q)
                  & (vcnt_n != V_MAX);
      end
    end
  end

  always_comb begin
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    hblank_d = hblank_q;
    vblank_d = hb_rise ? VBlank_in : vblank_q;
    locked_d = locked_q;
    blank    = HBlank_in | vblank_d;
    if (ce_pix) begin
      r_d      = blank ? '0 : R_in;
      g_d      = blank ? '0 : G_in;
      b_d      = blank ? '0 : B_in;
      hsync_d  = HSync_in ^ hs_pol_d;
      vsync_d  = VSync_in ^ vs_pol_d;
      hblank_d = HBlank_in;
      locked_d = h_ok_d & v_ok_d;
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      hb_prev_q <= 1'b0;
      h_seen_q  <= 1'b0;
      v_seen_q  <= 1'b0;
      h_meas_q  <= 1'b0;
      v_meas_q  <= 1'b0;
      h_ok_q    <= 1'b0;
      v_ok_q    <= 1'b0;
      hcnt_q    <= '0;
      hhi_q     <= '0;
      hlo_q     <= '0;
      vcnt_q    <= '0;
      vhi_q     <= '0;
      vlo_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      hs_pol_q  <= 1'b0;
      vs_pol_q  <= 1'b0;
      h_total_q <= '0;
      v_total_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      hb_prev_q <= hb_prev_d;
      h_seen_q  <= h_seen_d;
      v_seen_q  <= v_seen_d;
      h_meas_q  <= h_meas_d;
      v_meas_q  <= v_meas_d;
      h_ok_q    <= h_ok_d;
      v_ok_q    <= v_ok_d;
      hcnt_q    <= hcnt_d;
      hhi_q     <= hhi_d;
      hlo_q     <= hlo_d;
      vcnt_q    <= vcnt_d;
      vhi_q     <= vhi_d;
      vlo_q     <= vlo_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      hs_pol_q  <= hs_pol_d;
      vs_pol_q  <= vs_pol_d;
      h_total_q <= h_total_d;
      v_total_q <= v_total_d;
      locked_q  <= locked_d;
    end
  end

  assign R       = r_q;
  assign G       = g_q;
  assign B       = b_q;
  assign HSync   = hsync_q;
  assign VSync   = vsync_q;
  assign HBlank  = hblank_q;
  assign VBlank  = vblank_q;
  assign hs_pol  = hs_pol_q;
  assign vs_pol  = vs_pol_q;
  assign h_total = h_total_q;
  assign v_total = v_total_q;
  assign locked  = locked_q;

endmodule
